// File: rtl/snake_game_if.sv
// Control bus between the Snake game-flow sequencer and the rest of the game.
// With SNAKE_PAUSE_EN defined the bus also carries pauseButton.
interface snake_game_if #(
  parameter int LEVEL_W = 4
);
  logic               startButton;
  logic               foodEaten;
  logic               gameOver;
`ifdef SNAKE_PAUSE_EN
  logic               pauseButton;
`endif
  logic               gameReset;
  logic               moveTick;
  logic               playing;
  logic               showGameOver;
  logic [1:0]         countdown;
  logic [LEVEL_W-1:0] level;

  modport master (
    output startButton, foodEaten, gameOver,
`ifdef SNAKE_PAUSE_EN
    output pauseButton,
`endif
    input  gameReset, moveTick, playing, showGameOver, countdown, level
  );

  modport slave (
    input  startButton, foodEaten, gameOver,
`ifdef SNAKE_PAUSE_EN
    input  pauseButton,
`endif
    output gameReset, moveTick, playing, showGameOver, countdown, level
  );
endinterface

// File: rtl/snake_game_controller.sv
// Snake game-flow sequencer: idle, 3-2-1 countdown, playing with level-scaled move tick, game-over hold.
// Optional pause state enabled by defining SNAKE_PAUSE_EN.
module snake_game_controller #(
  parameter int unsigned BASE_PERIOD      = 5000000,
  parameter int unsigned PERIOD_STEP      = 500000,
  parameter int unsigned MIN_PERIOD       = 1000000,
  parameter int unsigned COUNTDOWN_CYCLES = 50000000,
  parameter int unsigned GAMEOVER_HOLD    = 100000000,
  parameter int unsigned FOODS_PER_LEVEL  = 4,
  parameter int          LEVEL_W          = 4
) (
  input logic         clock,
  input logic         reset,
  snake_game_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE,
    COUNTDOWN,
    PLAYING,
`ifdef SNAKE_PAUSE_EN
    PAUSED,
`endif
    GAME_OVER
  } state_t;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
  localparam logic [31:0] CD_LAST   = 32'(COUNTDOWN_CYCLES - 1);
  localparam logic [31:0] FOOD_LAST = 32'(FOODS_PER_LEVEL - 1);
  localparam logic [31:0] HOLD_MAX  = 32'(GAMEOVER_HOLD);
  localparam logic [31:0] PER_SPAN  = 32'(BASE_PERIOD - MIN_PERIOD);
  localparam logic [31:0] BASE_W    = 32'(BASE_PERIOD);
  localparam logic [31:0] MIN_W     = 32'(MIN_PERIOD);
  localparam logic [31:0] STEP_W    = 32'(PERIOD_STEP);

  state_t             state_q, state_d;
  logic [31:0]        cd_cnt_q, cd_cnt_d;
  logic [31:0]        per_cnt_q, per_cnt_d;
  logic [31:0]        hold_cnt_q, hold_cnt_d;
  logic [31:0]        food_cnt_q, food_cnt_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [1:0]         countdown_q, countdown_d;
  logic               prev_start_q, prev_start_d;
  logic               game_reset_q, game_reset_d;
  logic               move_tick_q, move_tick_d;
  logic               playing_q, playing_d;
  logic               show_go_q, show_go_d;
  logic               start_edge;
`ifdef SNAKE_PAUSE_EN
  logic               prev_pause_q, prev_pause_d;
  logic               pause_edge;
  assign pause_edge   = bus.pauseButton & ~prev_pause_q;
  assign prev_pause_d = bus.pauseButton;
`endif

  // Clamp is decided on the product so the subtraction can never wrap.
  logic [31:0] lvl_step, period, per_last;
  assign lvl_step = 32'(level_q) * STEP_W;
  assign period   = (lvl_step >= PER_SPAN) ? MIN_W : (BASE_W - lvl_step);
  assign per_last = period - 32'd1;

  assign start_edge   = bus.startButton & ~prev_start_q;
  assign prev_start_d = bus.startButton;

  always_comb begin
    state_d      = state_q;
    cd_cnt_d     = cd_cnt_q;
    per_cnt_d    = per_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    food_cnt_d   = food_cnt_q;
    level_d      = level_q;
    countdown_d  = countdown_q;
    game_reset_d = 1'b0;
    move_tick_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d     = COUNTDOWN;
          countdown_d = 2'd3;
          cd_cnt_d    = '0;
          level_d     = '0;
          food_cnt_d  = '0;
        end
      end
      COUNTDOWN: begin
        if (cd_cnt_q == CD_LAST) begin
          cd_cnt_d    = '0;
          countdown_d = countdown_q - 2'd1;
          if (countdown_q == 2'd1) begin
            state_d   = PLAYING;
            per_cnt_d = '0;
          end
        end else begin
          cd_cnt_d = cd_cnt_q + 32'd1;
        end
      end
      PLAYING: begin
        if (bus.gameOver) begin
          state_d    = GAME_OVER;
          hold_cnt_d = '0;
`ifdef SNAKE_PAUSE_EN
        end else if (pause_edge) begin
          state_d = PAUSED;
`endif
        end else begin
          // >= rather than == so a level-up that shrinks P below the count ticks at once.
          if (per_cnt_q >= per_last) begin
            per_cnt_d   = '0;
            move_tick_d = 1'b1;
          end else begin
            per_cnt_d = per_cnt_q + 32'd1;
          end
          if (bus.foodEaten) begin
            if (food_cnt_q == FOOD_LAST) begin
              food_cnt_d = '0;
              if (level_q != LEVEL_MAX) level_d = level_q + 1'b1;
            end else begin
              food_cnt_d = food_cnt_q + 32'd1;
            end
          end
        end
      end
`ifdef SNAKE_PAUSE_EN
      PAUSED: begin
        if (bus.gameOver) begin
          state_d    = GAME_OVER;
          hold_cnt_d = '0;
        end else if (pause_edge) begin
          state_d = PLAYING;
        end
      end
`endif
      GAME_OVER: begin
        if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end else if (start_edge) begin
          state_d      = COUNTDOWN;
          game_reset_d = 1'b1;
          countdown_d  = 2'd3;
          cd_cnt_d     = '0;
          level_d      = '0;
          food_cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    game_reset_d = game_reset_d | (state_d == IDLE);
    playing_d    = (state_d == PLAYING);
    show_go_d    = (state_d == GAME_OVER);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cd_cnt_q     <= '0;
      per_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      food_cnt_q   <= '0;
      level_q      <= '0;
      countdown_q  <= '0;
      prev_start_q <= 1'b1;
      game_reset_q <= 1'b1;
      move_tick_q  <= 1'b0;
      playing_q    <= 1'b0;
      show_go_q    <= 1'b0;
`ifdef SNAKE_PAUSE_EN
      prev_pause_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cd_cnt_q     <= cd_cnt_d;
      per_cnt_q    <= per_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      food_cnt_q   <= food_cnt_d;
      level_q      <= level_d;
      countdown_q  <= countdown_d;
      prev_start_q <= prev_start_d;
      game_reset_q <= game_reset_d;
      move_tick_q  <= move_tick_d;
      playing_q    <= playing_d;
      show_go_q    <= show_go_d;
`ifdef SNAKE_PAUSE_EN
      prev_pause_q <= prev_pause_d;
`endif
    end
  end

  assign bus.gameReset    = game_reset_q;
  assign bus.moveTick     = move_tick_q;
  assign bus.playing      = playing_q;
  assign bus.showGameOver = show_go_q;
  assign bus.countdown    = countdown_q;
  assign bus.level        = level_q;
endmodule

// File: tb/tb_snake_game_controller.sv
// Directed bench for snake_game_controller with small timing parameters.
module tb_snake_game_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  snake_game_if #(.LEVEL_W(4)) bus ();

  snake_game_controller #(
    .BASE_PERIOD(20), .PERIOD_STEP(4), .MIN_PERIOD(8), .COUNTDOWN_CYCLES(5),
    .GAMEOVER_HOLD(10), .FOODS_PER_LEVEL(2), .LEVEL_W(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    bus.startButton = 1'b1;
    bus.foodEaten   = 1'b0;
    bus.gameOver    = 1'b0;
`ifdef SNAKE_PAUSE_EN
    bus.pauseButton = 1'b0;
`endif
    reset = 1'b1;
    step(3);
    total_cnt++; if (bus.gameReset !== 1'b1) $display("FAIL rst_gameReset got %b want 1", bus.gameReset); else pass_cnt++;
    total_cnt++; if (bus.moveTick !== 1'b0) $display("FAIL rst_moveTick got %b want 0", bus.moveTick); else pass_cnt++;
    total_cnt++; if (bus.playing !== 1'b0 || bus.showGameOver !== 1'b0) $display("FAIL rst_flags got %b%b want 00", bus.playing, bus.showGameOver); else pass_cnt++;
    total_cnt++; if (bus.countdown !== 2'd0 || bus.level !== 4'd0) $display("FAIL rst_cd_level got %0d/%0d want 0/0", bus.countdown, bus.level); else pass_cnt++;
    reset = 1'b0;
    step(5);
    total_cnt++; if (bus.countdown !== 2'd0 || bus.gameReset !== 1'b1) $display("FAIL held_start_idle got cd=%0d gr=%b want 0/1", bus.countdown, bus.gameReset); else pass_cnt++;
  endtask

  task automatic test_countdown;
    bus.startButton = 1'b0;
    step(1);
    bus.startButton = 1'b1;
    step(1);
    total_cnt++; if (bus.gameReset !== 1'b0) $display("FAIL cd_gameReset got %b want 0", bus.gameReset); else pass_cnt++;
    for (int i = 0; i < 15; i++) begin
      logic [1:0] exp_cd;
      exp_cd = 2'(3 - i / 5);
      // gameOver/foodEaten must be ignored while counting down
      bus.gameOver  = (i >= 1 && i <= 13);
      bus.foodEaten = (i >= 1 && i <= 13);
      total_cnt++;
      if (bus.countdown !== exp_cd || bus.playing !== 1'b0 || bus.showGameOver !== 1'b0)
        $display("FAIL cd_digit[%0d] got cd=%0d pl=%b go=%b want cd=%0d pl=0 go=0", i, bus.countdown, bus.playing, bus.showGameOver, exp_cd);
      else pass_cnt++;
      step(1);
    end
    total_cnt++; if (bus.playing !== 1'b1 || bus.countdown !== 2'd0) $display("FAIL play_entry got pl=%b cd=%0d want 1/0", bus.playing, bus.countdown); else pass_cnt++;
    total_cnt++; if (bus.level !== 4'd0) $display("FAIL cd_level got %0d want 0", bus.level); else pass_cnt++;
  endtask

  task automatic test_ticks;
    for (int k = 0; k <= 40; k++) begin
      logic exp_t;
      exp_t = (k == 20 || k == 40);
      total_cnt++;
      if (bus.moveTick !== exp_t) $display("FAIL tick_l0[%0d] got %b want %b", k, bus.moveTick, exp_t); else pass_cnt++;
      step(1);
    end
  endtask

  task automatic test_level;
    int n;
    bus.foodEaten = 1'b1;
    step(2);
    bus.foodEaten = 1'b0;
    total_cnt++; if (bus.level !== 4'd1) $display("FAIL level1 got %0d want 1", bus.level); else pass_cnt++;
    n = 0;
    while (bus.moveTick !== 1'b1 && n < 64) begin step(1); n++; end
    step(1);
    total_cnt++; if (bus.moveTick !== 1'b0) $display("FAIL tick_width_l1 got %b want 0", bus.moveTick); else pass_cnt++;
    n = 1;
    while (bus.moveTick !== 1'b1 && n < 64) begin step(1); n++; end
    total_cnt++; if (n !== 16) $display("FAIL period_l1 got %0d want 16", n); else pass_cnt++;
    bus.foodEaten = 1'b1;
    step(6);
    bus.foodEaten = 1'b0;
    total_cnt++; if (bus.level !== 4'd4) $display("FAIL level4 got %0d want 4", bus.level); else pass_cnt++;
    n = 0;
    while (bus.moveTick !== 1'b1 && n < 64) begin step(1); n++; end
    step(1);
    n = 1;
    while (bus.moveTick !== 1'b1 && n < 64) begin step(1); n++; end
    total_cnt++; if (n !== 8) $display("FAIL period_clamp got %0d want 8", n); else pass_cnt++;
  endtask

  task automatic test_gameover;
    int n;
    n = 0;
    while (bus.moveTick !== 1'b1 && n < 64) begin step(1); n++; end
    total_cnt++; if (n >= 64) $display("FAIL go_tick_wait got timeout want tick"); else pass_cnt++;
    // one food now leaves the food counter one short of a level-up
    bus.foodEaten = 1'b1;
    step(1);
    bus.foodEaten = 1'b0;
    step(6);
    bus.gameOver  = 1'b1;
    bus.foodEaten = 1'b1;
    step(1);
    bus.foodEaten = 1'b0;
    bus.gameOver  = 1'b0;
    total_cnt++; if (bus.moveTick !== 1'b0) $display("FAIL go_no_tick got %b want 0", bus.moveTick); else pass_cnt++;
    total_cnt++; if (bus.showGameOver !== 1'b1 || bus.playing !== 1'b0) $display("FAIL go_flags got go=%b pl=%b want 1/0", bus.showGameOver, bus.playing); else pass_cnt++;
    total_cnt++; if (bus.level !== 4'd4) $display("FAIL go_level got %0d want 4", bus.level); else pass_cnt++;
  endtask

  task automatic test_restart;
    bus.startButton = 1'b0;
    step(3);
    bus.startButton = 1'b1;
    step(1);
    total_cnt++; if (bus.showGameOver !== 1'b1 || bus.gameReset !== 1'b0) $display("FAIL early_start got go=%b gr=%b want 1/0", bus.showGameOver, bus.gameReset); else pass_cnt++;
    bus.startButton = 1'b0;
    step(5);
    bus.startButton = 1'b1;
    step(1);
    total_cnt++; if (bus.showGameOver !== 1'b1 || bus.countdown !== 2'd0) $display("FAIL hold9_start got go=%b cd=%0d want 1/0", bus.showGameOver, bus.countdown); else pass_cnt++;
    total_cnt++; if (bus.moveTick !== 1'b0) $display("FAIL go_hold_tick got %b want 0", bus.moveTick); else pass_cnt++;
    bus.startButton = 1'b0;
    step(1);
    bus.startButton = 1'b1;
    step(1);
    total_cnt++; if (bus.gameReset !== 1'b1) $display("FAIL restart_pulse got %b want 1", bus.gameReset); else pass_cnt++;
    total_cnt++; if (bus.countdown !== 2'd3 || bus.level !== 4'd0 || bus.showGameOver !== 1'b0) $display("FAIL restart_state got cd=%0d lv=%0d go=%b want 3/0/0", bus.countdown, bus.level, bus.showGameOver); else pass_cnt++;
    step(1);
    total_cnt++; if (bus.gameReset !== 1'b0 || bus.countdown !== 2'd3) $display("FAIL restart_pulse_end got gr=%b cd=%0d want 0/3", bus.gameReset, bus.countdown); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int n;
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    total_cnt++; if (bus.gameReset !== 1'b1 || bus.countdown !== 2'd0 || bus.playing !== 1'b0) $display("FAIL rst_mid_cd got gr=%b cd=%0d pl=%b want 1/0/0", bus.gameReset, bus.countdown, bus.playing); else pass_cnt++;
    bus.startButton = 1'b0;
    step(1);
    bus.startButton = 1'b1;
    step(16);
    total_cnt++; if (bus.playing !== 1'b1) $display("FAIL replay_entry got %b want 1", bus.playing); else pass_cnt++;
    bus.foodEaten = 1'b1;
    step(2);
    bus.foodEaten = 1'b0;
    n = 0;
    while (bus.moveTick !== 1'b1 && n < 64) begin step(1); n++; end
    step(15);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    total_cnt++; if (bus.moveTick !== 1'b0 || bus.playing !== 1'b0) $display("FAIL rst_mid_play got mt=%b pl=%b want 0/0", bus.moveTick, bus.playing); else pass_cnt++;
    total_cnt++; if (bus.gameReset !== 1'b1 || bus.level !== 4'd0 || bus.countdown !== 2'd0) $display("FAIL rst_mid_vals got gr=%b lv=%0d cd=%0d want 1/0/0", bus.gameReset, bus.level, bus.countdown); else pass_cnt++;
  endtask

`ifdef SNAKE_PAUSE_EN
  task automatic test_pause;
    int n;
    bus.startButton = 1'b0;
    step(1);
    bus.startButton = 1'b1;
    step(16);
    n = 0;
    while (bus.moveTick !== 1'b1 && n < 64) begin step(1); n++; end
    step(5);
    bus.pauseButton = 1'b1;
    step(1);
    bus.pauseButton = 1'b0;
    total_cnt++; if (bus.playing !== 1'b0) $display("FAIL pause_playing got %b want 0", bus.playing); else pass_cnt++;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.moveTick === 1'b1) n++;
      step(1);
    end
    total_cnt++; if (n !== 0) $display("FAIL pause_ticks got %0d want 0", n); else pass_cnt++;
    bus.pauseButton = 1'b1;
    step(1);
    bus.pauseButton = 1'b0;
    total_cnt++; if (bus.playing !== 1'b1) $display("FAIL resume_playing got %b want 1", bus.playing); else pass_cnt++;
    n = 0;
    while (bus.moveTick !== 1'b1 && n < 64) begin step(1); n++; end
    total_cnt++; if (n !== 15) $display("FAIL resume_remaining got %0d want 15", n); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_countdown();
    test_ticks();
    test_level();
    test_gameover();
    test_restart();
    test_reset_mid();
`ifdef SNAKE_PAUSE_EN
    test_pause();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/snake_game_controller.md
Name: snake_game_controller

Overview:
- Top-level game-flow sequencer for the Snake design.
- Moves the game through its phases: idle/attract, start countdown, playing, and game-over hold.
- Generates the snake move tick, with a period that shrinks as food is eaten (level-up).
- Drives the clear/reset of the game datapath and the GameOver FSM. Consumes the GameOver FSM's gameOver flag.

Parameters:
- BASE_PERIOD, 5000000: clock cycles between move ticks at level 0.
- PERIOD_STEP, 500000: cycles removed from the move period per level.
- MIN_PERIOD, 1000000: floor on the move period.
- COUNTDOWN_CYCLES, 50000000: cycles per countdown digit.
- GAMEOVER_HOLD, 100000000: minimum cycles in GAME_OVER before a restart is accepted.
- FOODS_PER_LEVEL, 4: foods eaten per level increment.
- LEVEL_W, 4: width of the level counter.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; forces IDLE
- startButton  input  1  debounced start level; rising edge used
- foodEaten  input  1  one-cycle pulse from food/collision logic
- gameOver  input  1  level from GameOver FSM
- gameReset  output  1  clears snake, score and GameOver FSM
- moveTick  output  1  one-cycle snake advance pulse
- playing  output  1  high in PLAYING
- showGameOver  output  1  high in GAME_OVER
- countdown  output  2  digit to display (3,2,1), 0 otherwise
- level  output  LEVEL_W  current speed level

Behaviour:
- One clock; reset is synchronous and active-high.
- All outputs are registered. Reset values: state=IDLE, gameReset=1, moveTick=0, playing=0, showGameOver=0, countdown=0, level=0.
- All internal counters reset to 0. The start-edge register (prevStart) resets to 1, so a button held through reset does not start a game.
- Start edge: startEdge = startButton & ~prevStart, where prevStart is registered every cycle.
- IDLE:
  - gameReset=1.
  - On startEdge: next cycle go to COUNTDOWN, countdown=3, digit counter=0, level=0, food counter=0.
- COUNTDOWN:
  - gameReset=0.
  - Digit counter counts 0..COUNTDOWN_CYCLES-1. At terminal count, countdown decrements.
  - When terminal count occurs with countdown=1: go to PLAYING, countdown=0, period counter=0.
  - Total time in COUNTDOWN is exactly 3*COUNTDOWN_CYCLES cycles.
  - gameOver and foodEaten are ignored in this state.
- PLAYING:
  - playing=1.
  - Move period P = max(BASE_PERIOD - level*PERIOD_STEP, MIN_PERIOD). Compute at 32-bit width with no underflow: if level*PERIOD_STEP >= BASE_PERIOD - MIN_PERIOD, then P = MIN_PERIOD.
  - Period counter runs 0..P-1. moveTick=1 for the single cycle after the counter reaches P-1, and the counter wraps to 0. The first tick is P cycles after entering PLAYING.
  - If level changes mid-period, the new P applies at once. If counter >= new P-1, tick on the next cycle.
  - foodEaten increments the food counter. When it reaches FOODS_PER_LEVEL, it clears and level increments, saturating at 2^LEVEL_W-1.
  - gameOver=1: next state GAME_OVER. moveTick is forced 0 from that cycle on. A simultaneous foodEaten is discarded.
- GAME_OVER:
  - showGameOver=1, playing=0, level held.
  - Hold counter counts up to GAMEOVER_HOLD. startEdge is ignored until the hold counter reaches GAMEOVER_HOLD.
  - After that, startEdge pulses gameReset=1 for exactly 1 cycle. The same transition enters COUNTDOWN (countdown=3, level=0, food counter=0).
- reset asserted in any state returns to IDLE next edge with the reset values above; it overrides every other event.
- moveTick never asserts outside PLAYING (or PAUSED, see Optional Feature: never there either).

Optional Feature:
- Macro: SNAKE_PAUSE_EN.
- With the macro defined:
  - Adds port pauseButton input 1 and state PAUSED.
  - A rising edge of pauseButton (prevPause resets to 1) in PLAYING goes to PAUSED. A rising edge in PAUSED returns to PLAYING.
  - In PAUSED: period counter frozen, moveTick=0, playing=0, foodEaten ignored. gameOver=1 still goes to GAME_OVER.
  - Pause edges are ignored in all other states.
- Without the macro: no pauseButton port, no PAUSED state, behaviour exactly as above.

Test Plan:
Parameters for all scenarios: BASE_PERIOD=20, PERIOD_STEP=4, MIN_PERIOD=8, COUNTDOWN_CYCLES=5, GAMEOVER_HOLD=10, FOODS_PER_LEVEL=2.
1. Reset held with startButton=1, then release, keeping startButton=1 -> stays IDLE, gameReset=1. Drop and re-raise startButton -> countdown=3,2,1 each for 5 cycles, then playing=1 exactly 15 cycles after entry.
2. PLAYING, no food -> moveTick single-cycle pulses every 20 cycles, first tick 20 cycles after playing rises.
3. 2 foodEaten pulses -> level=1, tick period 16. 6 further pulses -> level=4, period clamped to 8 (not 4).
4. gameOver=1 together with foodEaten, in the cycle a tick is due -> no moveTick, level unchanged, showGameOver=1 next cycle.
5. In GAME_OVER: startEdge at hold cycle 3 -> ignored. startEdge after 10 cycles -> gameReset 1-cycle pulse, countdown=3, level=0.
6. Assert reset mid-COUNTDOWN and mid-PLAYING -> next edge IDLE, moveTick=0, countdown=0, gameReset=1. With SNAKE_PAUSE_EN: pause edge freezes ticks, a second edge resumes with the remaining period preserved.
